// File: rtl/apb_req_arbiter.sv
// -----------------------------------------------------------------------------
// apb_req_arbiter
//
// Shares one APB bus among NUM_REQ local requesters. A round-robin arbiter
// picks one pending request per IDLE cycle, the FSM walks it through the APB
// SETUP and ACCESS phases, honours PREADY wait states, and aborts a transfer
// whose slave keeps PREADY low for TIMEOUT consecutive ACCESS cycles.
//
// Ports
//   PCLK, PRESET_N   bus clock (posedge) and asynchronous active-low reset
//   req_valid        per-requester request strobe, held until its req_done
//   req_write        per-requester direction (1 = write)
//   req_addr         flattened addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata        flattened write data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_done         one-hot, one-cycle completion pulse
//   req_err          qualifies req_done: 1 = transfer aborted by timeout
//   req_rdata        read data, qualifies req_done (0 for writes and aborts)
//   PADDR, PWDATA, PWRITE, PSEL, PENABLE   APB master outputs (registered)
//   PRDATA, PREADY   APB slave responses
// -----------------------------------------------------------------------------
module apb_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                             PCLK,
  input  logic                             PRESET_N,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               req_done,
  output logic                             req_err,
  output logic [DATA_WIDTH-1:0]            req_rdata,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic                             PWRITE,
  output logic                             PSEL,
  output logic                             PENABLE,
  input  logic [DATA_WIDTH-1:0]            PRDATA,
  input  logic                             PREADY
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   winner;
  logic [CNT_W-1:0]   tmo_cnt;

  logic [NUM_REQ-1:0] eligible;
  logic               grant_found;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W:0]     scan_sum;
  logic [IDX_W-1:0]   scan_idx;

  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_write;

  logic [IDX_W-1:0]   next_ptr;

  // Round-robin search starting at rr_ptr with wrap. The requester whose
  // req_done is high this cycle still shows its old request (it may only
  // change it in the following cycle), so it is masked to avoid a duplicate.
  always_comb begin
    // NOTE: every variable gets a default before any branch so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    eligible    = req_valid & ~req_done;
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
      if (scan_sum >= NUM_REQ_W) begin
        scan_sum = scan_sum - NUM_REQ_W;
      end
      scan_idx = scan_sum[IDX_W-1:0];
      if (!grant_found && eligible[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // Winner's request fields, selected with constant slices.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_write = req_write[i];
      end
    end
  end

  // Pointer moves just past the finishing requester, wrapping at NUM_REQ.
  assign next_ptr = (winner == LAST_IDX) ? '0 : winner + IDX_W'(1);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      winner    <= '0;
      tmo_cnt   <= '0;
      req_done  <= '0;
      req_err   <= 1'b0;
      req_rdata <= '0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PWRITE    <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
    end else begin
      // Response outputs are pulses: cleared here, set only on completion.
      req_done  <= '0;
      req_err   <= 1'b0;
      req_rdata <= '0;

      case (state)
        ST_IDLE: begin
          if (grant_found) begin
            winner <= grant_idx;
            PADDR  <= sel_addr;
            PWDATA <= sel_wdata;
            PWRITE <= sel_write;
            PSEL   <= 1'b1;
            state  <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          PENABLE <= 1'b1;
          state   <= ST_ACCESS;
        end

        ST_ACCESS: begin
          if (PREADY) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            req_done  <= NUM_REQ'(1) << winner;
            req_rdata <= PWRITE ? '0 : PRDATA;
            rr_ptr    <= next_ptr;
            tmo_cnt   <= '0;
            state     <= ST_IDLE;
          end else if (tmo_cnt == CNT_MAX) begin
            // Slave hung: release the bus and report the abort.
            PSEL     <= 1'b0;
            PENABLE  <= 1'b0;
            req_done <= NUM_REQ'(1) << winner;
            req_err  <= 1'b1;
            rr_ptr   <= next_ptr;
            tmo_cnt  <= '0;
            state    <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_req_arbiter
//
// Self-checking bench for apb_req_arbiter: directed scenarios for reset,
// single write, wait-stated read, round-robin order, timeout abort and reset
// during a transfer, then a randomized run checked against a transaction-level
// reference model of requesters, round-robin fairness and APB phases.
// -----------------------------------------------------------------------------
module tb_apb_req_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic              PCLK;
  logic              PRESET_N;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_write;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [N-1:0]      req_done;
  logic              req_err;
  logic [DW-1:0]     req_rdata;
  logic [AW-1:0]     PADDR;
  logic [DW-1:0]     PWDATA;
  logic              PWRITE;
  logic              PSEL;
  logic              PENABLE;
  logic [DW-1:0]     PRDATA;
  logic              PREADY;

  int errors;
  int checks;

  apb_req_arbiter #(
    .NUM_REQ   (N),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT   (TO)
  ) dut (
    .PCLK     (PCLK),
    .PRESET_N (PRESET_N),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_done (req_done),
    .req_err  (req_err),
    .req_rdata(req_rdata),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PWRITE   (PWRITE),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]           = v;
    req_write[i]           = w;
    req_addr[i*AW +: AW]   = a;
    req_wdata[i*DW +: DW]  = d;
  endtask

  task automatic do_reset();
    PRESET_N  = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    PREADY    = 1'b1;
    PRDATA    = '0;
    repeat (2) @(posedge PCLK);
    #1;
    PRESET_N = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge PCLK);
    #1;
    PRESET_N = 1'b0;
    set_req(1, 1'b1, 1'b1, 32'h0000_0040, 32'h1111_2222);
    #1;
    checks++;
    if ({PSEL, PENABLE, PWRITE, req_done, req_err} !== '0 || PADDR !== '0 ||
        PWDATA !== '0 || req_rdata !== '0) begin
      errors++;
      $display("FAIL rst_values: psel=%b pen=%b pwrite=%b done=%b err=%b paddr=%h pwdata=%h rdata=%h, all required 0",
               PSEL, PENABLE, PWRITE, req_done, req_err, PADDR, PWDATA, req_rdata);
    end
    tick();
    tick();
    checks++;
    if ({PSEL, PENABLE, req_done} !== '0) begin
      errors++;
      $display("FAIL rst_hold: psel=%b pen=%b done=%b while in reset, required 0", PSEL, PENABLE, req_done);
    end
    req_valid = '0;
    PRESET_N  = 1'b1;
    tick();
    checks++;
    if ({PSEL, PENABLE} !== 2'b00) begin
      errors++;
      $display("FAIL rst_idle: psel=%b pen=%b with no request, required 00", PSEL, PENABLE);
    end
  endtask

  task automatic test_single_write();
    PREADY = 1'b1;
    set_req(2, 1'b1, 1'b1, 32'h0000_0010, 32'hA5A5_0001);
    tick();
    checks++;
    if ({PSEL, PENABLE, PWRITE} !== 3'b101 || PADDR !== 32'h10 || PWDATA !== 32'hA5A5_0001 || req_done !== '0) begin
      errors++;
      $display("FAIL sw_setup: psel=%b pen=%b pwrite=%b paddr=%h pwdata=%h done=%b, required 1 0 1 10 a5a50001 0000",
               PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_done);
    end
    tick();
    checks++;
    if ({PSEL, PENABLE} !== 2'b11 || req_done !== '0) begin
      errors++;
      $display("FAIL sw_access: psel=%b pen=%b done=%b, required 1 1 0000", PSEL, PENABLE, req_done);
    end
    tick();
    checks++;
    if ({PSEL, PENABLE} !== 2'b00 || req_done !== 4'b0100 || req_err !== 1'b0 || req_rdata !== '0) begin
      errors++;
      $display("FAIL sw_done: psel=%b pen=%b done=%b err=%b rdata=%h, required 0 0 0100 0 0",
               PSEL, PENABLE, req_done, req_err, req_rdata);
    end
    // The request is still held during this edge; it must not be re-granted.
    tick();
    checks++;
    if (req_done !== '0 || PSEL !== 1'b0) begin
      errors++;
      $display("FAIL sw_after: done=%b psel=%b, required 0000 0", req_done, PSEL);
    end
    req_valid[2] = 1'b0;
  endtask

  task automatic test_wait_read();
    PREADY = 1'b0;
    PRDATA = $urandom;
    set_req(0, 1'b1, 1'b0, 32'h0000_0020, 32'h5555_0000);
    tick();
    checks++;
    if ({PSEL, PENABLE, PWRITE} !== 3'b100 || PADDR !== 32'h20) begin
      errors++;
      $display("FAIL wr_setup: psel=%b pen=%b pwrite=%b paddr=%h, required 1 0 0 20", PSEL, PENABLE, PWRITE, PADDR);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({PSEL, PENABLE, PWRITE} !== 3'b110 || PADDR !== 32'h20 || PWDATA !== 32'h5555_0000 || req_done !== '0) begin
        errors++;
        $display("FAIL wr_access%0d: psel=%b pen=%b pwrite=%b paddr=%h pwdata=%h done=%b, required 1 1 0 20 55550000 0000",
                 k, PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_done);
      end
      if (k == 3) begin
        PREADY = 1'b1;
        PRDATA = 32'hDEAD_BEEF;
      end else begin
        PREADY = 1'b0;
        PRDATA = $urandom;
      end
    end
    tick();
    checks++;
    if ({PSEL, PENABLE} !== 2'b00 || req_done !== 4'b0001 || req_err !== 1'b0 || req_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL wr_done: psel=%b pen=%b done=%b err=%b rdata=%h, required 0 0 0001 0 deadbeef",
               PSEL, PENABLE, req_done, req_err, req_rdata);
    end
    tick();
    checks++;
    if (req_done !== '0 || req_rdata !== '0) begin
      errors++;
      $display("FAIL wr_clear: done=%b rdata=%h, required 0000 0", req_done, req_rdata);
    end
    req_valid[0] = 1'b0;
  endtask

  task automatic test_round_robin();
    int           order[5];
    int           g;
    int           idle_run;
    int           budget;
    int           id;
    logic [N-1:0] done_last;
    logic [7:0]   seq;
    order     = '{0, 1, 2, 3, 0};
    g         = 0;
    idle_run  = 0;
    budget    = 0;
    done_last = '0;
    seq       = 8'd0;
    do_reset();
    // Requester id is encoded in PADDR[15:8].
    for (int i = 0; i < N; i++) begin
      set_req(i, 1'b1, 1'(i & 1), {16'h0, 8'(i), 8'h00}, 32'h1000 + i);
    end
    PREADY = 1'b1;
    while (g < 5 && budget < 60) begin
      tick();
      budget++;
      if (PSEL && !PENABLE) begin
        id = int'(PADDR[15:8]);
        checks++;
        if (id !== order[g]) begin
          errors++;
          $display("FAIL rr_order%0d: granted requester %0d, required %0d", g, id, order[g]);
        end
        if (g > 0) begin
          checks++;
          if (idle_run !== 1) begin
            errors++;
            $display("FAIL rr_gap%0d: %0d PSEL-low cycles between transfers, required 1", g, idle_run);
          end
        end
        g++;
        idle_run = 0;
      end else if (!PSEL) begin
        idle_run++;
      end
      for (int i = 0; i < N; i++) begin
        if (done_last[i]) begin
          seq++;
          set_req(i, 1'b1, 1'(i & 1), {16'h0, 8'(i), seq}, 32'h2000 + 32'(seq));
        end
      end
      done_last = req_done;
    end
    checks++;
    if (g != 5) begin
      errors++;
      $display("FAIL rr_budget: only %0d grants seen in 60 cycles, required 5", g);
    end
  endtask

  task automatic test_timeout();
    int acc;
    do_reset();
    PREADY = 1'b0;
    PRDATA = 32'hCAFE_F00D;
    set_req(1, 1'b1, 1'b0, 32'h0000_0044, 32'h0);
    tick();
    acc = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (!PENABLE) break;
      acc++;
    end
    checks++;
    if (acc !== TO) begin
      errors++;
      $display("FAIL to_len: %0d ACCESS cycles before abort, required %0d", acc, TO);
    end
    checks++;
    if ({PSEL, PENABLE} !== 2'b00 || req_done !== 4'b0010 || req_err !== 1'b1 || req_rdata !== '0) begin
      errors++;
      $display("FAIL to_abort: psel=%b pen=%b done=%b err=%b rdata=%h, required 0 0 0010 1 0",
               PSEL, PENABLE, req_done, req_err, req_rdata);
    end
    tick();
    checks++;
    if (req_done !== '0 || req_err !== 1'b0) begin
      errors++;
      $display("FAIL to_clear: done=%b err=%b, required 0000 0", req_done, req_err);
    end
    req_valid[1] = 1'b0;
    PREADY = 1'b1;
    PRDATA = 32'h1234_5678;
    set_req(3, 1'b1, 1'b0, 32'h0000_0088, 32'h0);
    tick();
    checks++;
    if ({PSEL, PENABLE} !== 2'b10 || PADDR !== 32'h88) begin
      errors++;
      $display("FAIL to_next_setup: psel=%b pen=%b paddr=%h, required 1 0 88", PSEL, PENABLE, PADDR);
    end
    tick();
    tick();
    checks++;
    if (req_done !== 4'b1000 || req_err !== 1'b0 || req_rdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL to_next_done: done=%b err=%b rdata=%h, required 1000 0 12345678", req_done, req_err, req_rdata);
    end
    tick();
    req_valid[3] = 1'b0;
  endtask

  task automatic test_reset_mid();
    // Move the pointer to 3 with a completed transfer by requester 2.
    PREADY = 1'b1;
    set_req(2, 1'b1, 1'b1, 32'h0000_0050, 32'h0BAD_0002);
    tick();
    tick();
    tick();
    checks++;
    if (req_done !== 4'b0100) begin
      errors++;
      $display("FAIL rm_prep: done=%b, required 0100", req_done);
    end
    tick();
    req_valid[2] = 1'b0;
    PREADY = 1'b0;
    set_req(0, 1'b1, 1'b1, 32'h0000_00A0, 32'h0);
    set_req(3, 1'b1, 1'b1, 32'h0000_00A3, 32'h0);
    tick();
    checks++;
    if (PSEL !== 1'b1 || PADDR !== 32'hA3) begin
      errors++;
      $display("FAIL rm_pre_grant: psel=%b paddr=%h, required 1 a3", PSEL, PADDR);
    end
    tick();
    tick();
    #2;
    PRESET_N = 1'b0;
    #1;
    checks++;
    if ({PSEL, PENABLE} !== 2'b00 || req_done !== '0) begin
      errors++;
      $display("FAIL rm_async: psel=%b pen=%b done=%b right after reset, required 0 0 0000", PSEL, PENABLE, req_done);
    end
    tick();
    checks++;
    if ({PSEL, PENABLE} !== 2'b00 || req_done !== '0) begin
      errors++;
      $display("FAIL rm_held: psel=%b pen=%b done=%b in reset, required 0 0 0000", PSEL, PENABLE, req_done);
    end
    PRESET_N = 1'b1;
    PREADY   = 1'b1;
    tick();
    checks++;
    if (PSEL !== 1'b1 || PADDR !== 32'hA0) begin
      errors++;
      $display("FAIL rm_first: psel=%b paddr=%h after reset, required 1 a0", PSEL, PADDR);
    end
    tick();
    tick();
    checks++;
    if (req_done !== 4'b0001 || req_err !== 1'b0) begin
      errors++;
      $display("FAIL rm_done: done=%b err=%b, required 0001 0", req_done, req_err);
    end
  endtask

  // Randomized traffic checked against a transaction-level model: pending
  // requests per requester, round-robin choice from a pointer, and the APB
  // phase sequence SETUP -> ACCESS (wait states) -> completion or timeout.
  task automatic test_protocol_random();
    logic          pend[N];
    logic          hold[N];
    logic          mw[N];
    logic [AW-1:0] ma[N];
    logic [DW-1:0] md[N];
    int            waited[N];
    int            mptr;
    int            phase;
    int            cur;
    int            acc;
    int            g;
    bit            hang;
    logic          rdy;
    logic [DW-1:0] rd;
    logic          exp_psel;
    logic          exp_pen;
    logic [N-1:0]  exp_done;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;

    do_reset();
    for (int i = 0; i < N; i++) begin
      pend[i]   = 1'b0;
      hold[i]   = 1'b0;
      mw[i]     = 1'b0;
      ma[i]     = '0;
      md[i]     = '0;
      waited[i] = 0;
    end
    mptr  = 0;
    phase = 0;
    cur   = 0;
    acc   = 0;
    hang  = 1'b0;

    for (int cyc = 0; cyc < 1000; cyc++) begin
      rdy = PREADY;
      rd  = PRDATA;
      tick();
      exp_done  = '0;
      exp_err   = 1'b0;
      exp_rdata = '0;
      exp_psel  = 1'b0;
      exp_pen   = 1'b0;
      case (phase)
        0: begin
          g = -1;
          for (int k = 0; k < N; k++) begin
            int j;
            j = (mptr + k) % N;
            if (g < 0 && pend[j]) g = j;
          end
          if (g >= 0) begin
            checks++;
            if (waited[g] > N - 1) begin
              errors++;
              $display("FAIL rnd_starve: requester %0d waited %0d transfers, required at most %0d", g, waited[g], N - 1);
            end
            for (int j = 0; j < N; j++) begin
              if (j != g && pend[j]) waited[j]++;
            end
            cur      = g;
            phase    = 1;
            hang     = ($urandom_range(0, 9) == 0);
            exp_psel = 1'b1;
          end
        end
        1: begin
          exp_psel = 1'b1;
          exp_pen  = 1'b1;
          phase    = 2;
          acc      = 1;
        end
        default: begin
          if (rdy || acc == TO) begin
            exp_done  = N'(1) << cur;
            exp_err   = !rdy;
            exp_rdata = (rdy && !mw[cur]) ? rd : '0;
            pend[cur] = 1'b0;
            hold[cur] = 1'b1;
            mptr      = (cur + 1) % N;
            phase     = 0;
          end else begin
            exp_psel = 1'b1;
            exp_pen  = 1'b1;
            acc++;
          end
        end
      endcase

      checks++;
      if ({PSEL, PENABLE} !== {exp_psel, exp_pen}) begin
        errors++;
        $display("FAIL rnd_ctrl@%0d: psel=%b pen=%b, required %b %b", cyc, PSEL, PENABLE, exp_psel, exp_pen);
      end
      checks++;
      if (req_done !== exp_done || req_err !== exp_err || req_rdata !== exp_rdata) begin
        errors++;
        $display("FAIL rnd_resp@%0d: done=%b err=%b rdata=%h, required %b %b %h",
                 cyc, req_done, req_err, req_rdata, exp_done, exp_err, exp_rdata);
      end
      if (exp_psel) begin
        checks++;
        if (PADDR !== ma[cur] || PWRITE !== mw[cur] || PWDATA !== md[cur]) begin
          errors++;
          $display("FAIL rnd_bus@%0d: paddr=%h pwrite=%b pwdata=%h, required %h %b %h (requester %0d)",
                   cyc, PADDR, PWRITE, PWDATA, ma[cur], mw[cur], md[cur], cur);
        end
      end

      // Requesters: hold through the done cycle, change only the cycle after.
      for (int i = 0; i < N; i++) begin
        if (hold[i] && !exp_done[i]) begin
          hold[i] = 1'b0;
          if ($urandom_range(0, 1) == 1) begin
            pend[i]   = 1'b1;
            waited[i] = 0;
            mw[i]     = 1'($urandom_range(0, 1));
            ma[i]     = AW'($urandom);
            md[i]     = DW'($urandom);
            set_req(i, 1'b1, mw[i], ma[i], md[i]);
          end else begin
            req_valid[i] = 1'b0;
          end
        end else if (!hold[i] && !pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i]   = 1'b1;
          waited[i] = 0;
          mw[i]     = 1'($urandom_range(0, 1));
          ma[i]     = AW'($urandom);
          md[i]     = DW'($urandom);
          set_req(i, 1'b1, mw[i], ma[i], md[i]);
        end
      end
      if (phase == 2) begin
        PREADY = hang ? 1'b0 : ($urandom_range(0, 2) != 0);
      end else begin
        PREADY = 1'($urandom_range(0, 1));
      end
      PRDATA = DW'($urandom);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    errors    = 0;
    checks    = 0;
    PRESET_N  = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    PREADY    = 1'b1;
    PRDATA    = '0;

    test_reset();
    test_single_write();
    test_wait_read();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_protocol_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Multi-requester APB master front end: shares one APB bus among NUM_REQ local requesters.
- Arbitrates round-robin, sequences the IDLE/SETUP/ACCESS protocol, honours PREADY wait states and aborts hung slaves by timeout.
- Drives the master side of the team's APB interface; its bus outputs must pass the interface's protocol assertions.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 32, PADDR width.
- DATA_WIDTH, 32, PWDATA/PRDATA width.
- TIMEOUT, 16, max consecutive ACCESS cycles with PREADY=0 before abort (>=2).

Ports:
- PCLK  in  1  bus clock; all logic on posedge.
- PRESET_N  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester transfer request.
- req_write  in  NUM_REQ  per-requester direction (1=write).
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data; requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- req_done  out  NUM_REQ  one-cycle completion pulse, one-hot.
- req_err  out  1  valid with req_done; 1 = timeout abort.
- req_rdata  out  DATA_WIDTH  read data; valid with req_done.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PWRITE  out  1  APB direction.
- PSEL  out  1  APB select (single slave).
- PENABLE  out  1  APB enable.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY  in  1  APB ready.

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM=IDLE, rr pointer=0, timeout counter=0.
- All outputs registered.
- Requester contract:
  - hold req_valid, req_write, req_addr, req_wdata stable from assertion until its req_done pulse;
  - deassert or present a new request in the cycle after req_done.
- IDLE:
  - PSEL=0, PENABLE=0.
  - If any req_valid at a clock edge, select the first set bit searching from rr pointer upward with wrap (rr, rr+1 … NUM_REQ-1, 0 …).
  - Latch the winner's index, addr, wdata and write onto PADDR/PWDATA/PWRITE.
  - Set PSEL=1 and go to SETUP.
  - PWDATA is driven even for reads (don't-care to the slave).
- SETUP: lasts exactly one cycle; next edge sets PENABLE=1 and goes to ACCESS. PADDR/PWDATA/PWRITE/PSEL stay stable.
- ACCESS:
  - PREADY=1 at an edge: PSEL=0, PENABLE=0; pulse req_done[winner] with req_err=0; req_rdata=PRDATA for reads, 0 for writes; rr pointer=(winner+1) mod NUM_REQ; go to IDLE.
  - PREADY=0: stay in ACCESS with all bus signals stable; increment the timeout counter.
  - Counter reaches TIMEOUT-1 with PREADY still 0: abort as above but req_err=1, req_rdata=0.
  - Counter clears on every exit from ACCESS.
- Latency: request seen at edge N -> SETUP after N -> ACCESS after N+1 -> zero-wait completion at edge N+2, req_done high during cycle N+2..N+3.
- Back-to-back: always one IDLE cycle between transfers, so PSEL drops for at least one cycle.
- req_done, req_err and req_rdata are held 0 except in the done cycle.
- The pointer advances only on completion or abort, so every valid requester is granted within NUM_REQ transfers.
- req_valid dropping mid-transfer: ignored; the transfer completes and req_done still pulses.
- Reset mid-transfer: immediate return to reset values; no req_done is issued for the aborted transfer.
- Simultaneous requests: only one is granted per IDLE; the others stay pending.

Test Plan:
- Single write: req_valid[2]=1, addr=0x10, wdata=0xA5A5_0001, PREADY=1 -> PSEL at N+1, PENABLE at N+2, req_done=4'b0100 one cycle, req_err=0.
- Wait-state read: req 0 read addr 0x20, PREADY low 3 ACCESS cycles, PRDATA=0xDEAD_BEEF -> ACCESS lasts 4 cycles with bus stable, req_rdata=0xDEAD_BEEF with req_done[0].
- Round-robin: all four requesters held valid, PREADY=1 -> grant order 0,1,2,3,0; transfers separated by one PSEL=0 cycle.
- Timeout: TIMEOUT=16, PREADY stuck 0 -> abort after 16 ACCESS cycles, req_err=1, req_rdata=0, PSEL/PENABLE=0; next request proceeds normally.
- Reset mid-ACCESS: PRESET_N low during a wait-stated transfer -> PSEL/PENABLE/req_done=0 immediately; after release, requester 0 is granted first.
- Protocol: random requests and PREADY over 1000 cycles -> zero interface assertion failures; no requester unserved more than NUM_REQ transfers.
